// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - consumer-side word/flag handshake of the UART receiver
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 ready;
    logic                 ack;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out, ready, frame_err, parity_err, overrun,
        input  ack
    );

    modport slave (
        input  data_out, ready, frame_err, parity_err, overrun,
        output ack
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with held word and error flags
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rx,
    output logic              led_rx,
    uart_rx_param_if.master   rif
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int IW   = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 rx_m, rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_bad;
    logic                 tick;
    logic                 done;
    logic                 stop_fail;
    logic                 par_bad;

    // The sample point is the edge on which the counter would fall from 1 to 0.
    assign tick      = (cnt == CW'(1));
    assign done      = (state == S_STOP) && tick && (idx == IW'(STOP_BITS - 1));
    assign stop_fail = stop_bad | ~rx_s;
    assign par_bad   = (PARITY != 0) && (((^shreg) ^ (PARITY == 1)) != par_bit);
    assign led_rx    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            rx_m           <= 1'b1;
            rx_s           <= 1'b1;
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            stop_bad       <= 1'b0;
            rif.data_out   <= '0;
            rif.ready      <= 1'b0;
            rif.frame_err  <= 1'b0;
            rif.parity_err <= 1'b0;
            rif.overrun    <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            if (cnt != '0) cnt <= cnt - CW'(1);

            case (state)
                S_IDLE: if (!rx_s) begin
                    cnt   <= CW'(HALF);
                    state <= S_START;
                end
                S_START: if (tick) begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end else begin
                        cnt   <= CW'(CLKS_PER_BIT);
                        idx   <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                    cnt   <= CW'(CLKS_PER_BIT);
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx      <= '0;
                        stop_bad <= 1'b0;
                        state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_PARITY: if (tick) begin
                    par_bit <= rx_s;
                    cnt     <= CW'(CLKS_PER_BIT);
                    state   <= S_STOP;
                end
                S_STOP: if (tick) begin
                    cnt <= CW'(CLKS_PER_BIT);
                    if (done) begin
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        idx      <= idx + IW'(1);
                        stop_bad <= stop_fail;
                    end
                end
                S_BREAK: if (rx_s) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // An ack arriving with the completion frees the holding register for the new word.
            if (done) begin
                if (!rif.ready || rif.ack) begin
                    rif.data_out   <= shreg;
                    rif.frame_err  <= stop_fail;
                    rif.parity_err <= par_bad;
                    rif.ready      <= 1'b1;
                end else begin
                    rif.overrun <= 1'b1;
                end
            end else if (rif.ack && rif.ready) begin
                rif.ready      <= 1'b0;
                rif.frame_err  <= 1'b0;
                rif.parity_err <= 1'b0;
                rif.overrun    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param (8N1 and 7E2 instances)
module tb_uart_rx_param;
    localparam int C = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;
    logic rx0, rx1;
    logic led0, led1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(7)) if1 ();

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .clr(clr), .rx(rx0), .led_rx(led0), .rif(if0.master)
    );
    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .clr(clr), .rx(rx1), .led_rx(led1), .rif(if1.master)
    );

    int tests = 0;
    int fails = 0;

    logic [8:0] e_data [2];
    bit         e_rdy  [2];
    bit         e_fe   [2];
    bit         e_pe   [2];
    bit         e_ov   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_data(input int d);
        return d ? 32'(if1.data_out) : 32'(if0.data_out);
    endfunction

    function automatic logic [31:0] obs_flags(input int d);
        if (d) return {28'd0, if1.ready, if1.frame_err, if1.parity_err, if1.overrun};
        return {28'd0, if0.ready, if0.frame_err, if0.parity_err, if0.overrun};
    endfunction

    function automatic logic [31:0] obs_led(input int d);
        return d ? 32'(led1) : 32'(led0);
    endfunction

    function automatic logic [31:0] exp_flags(input int d);
        return {28'd0, e_rdy[d], e_fe[d], e_pe[d], e_ov[d]};
    endfunction

    task automatic check_state(input string tag, input int d);
        check($sformatf("%s.u%0d.data", tag, d), obs_data(d), 32'(e_data[d]));
        check($sformatf("%s.u%0d.flags", tag, d), obs_flags(d), exp_flags(d));
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d) rx1 = v; else rx0 = v;
    endtask

    task automatic set_ack(input int d, input logic v);
        if (d) if1.ack = v; else if0.ack = v;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_data[d] = '0; e_rdy[d] = 0; e_fe[d] = 0; e_pe[d] = 0; e_ov[d] = 0;
        end
    endtask

    // Drives one frame; the completion edge is 3 sync/detect edges + half a bit + remaining fields.
    task automatic send(input int d, input logic [8:0] val, input bit pflip, input bit stop0, input bit ack_done);
        int nd, np, ns, done_e, e;
        bit bits[$];
        bit par;
        logic [8:0] v;
        nd = d ? 7 : 8;
        np = d ? 1 : 0;
        ns = d ? 2 : 1;
        v = val & 9'((1 << nd) - 1);
        par = bit'(($countones(v) % 2) != 0) ^ pflip;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(v[i]);
        if (np != 0) bits.push_back(par);
        for (int s = 0; s < ns; s++) bits.push_back(!(stop0 && s == ns - 1));
        done_e = 3 + C / 2 + (nd + np + ns) * C;
        @(posedge clk); #1;
        e = 0;
        foreach (bits[k]) begin
            set_rx(d, bits[k]);
            repeat (C) begin
                @(posedge clk); e++; #1;
                if (e == C) check($sformatf("led_mid.u%0d", d), obs_led(d), 32'd1);
                if (e == done_e - 1) begin
                    check_state("pre_done", d);
                    if (ack_done) set_ack(d, 1'b1);
                end
                if (e == done_e) begin
                    set_ack(d, 1'b0);
                    if (!e_rdy[d] || ack_done) begin
                        e_data[d] = v;
                        e_fe[d]   = stop0;
                        e_pe[d]   = (np != 0) && ((($countones(v) % 2) != 0) != par);
                        e_rdy[d]  = 1;
                    end else begin
                        e_ov[d] = 1;
                    end
                    check_state("done", d);
                end
            end
        end
    endtask

    task automatic do_ack(input int d);
        @(posedge clk); #1 set_ack(d, 1'b1);
        @(posedge clk); #1 set_ack(d, 1'b0);
        if (e_rdy[d]) begin
            e_rdy[d] = 0; e_fe[d] = 0; e_pe[d] = 0; e_ov[d] = 0;
        end
        check_state("ack", d);
    endtask

    task automatic line_idle(input int d, input int n);
        set_rx(d, 1'b1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; rx0 = 1'b1; rx1 = 1'b1; if0.ack = 1'b0; if1.ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_state("reset", 0);
        check_state("reset", 1);
        check("reset.led0", obs_led(0), 32'd0);
        check("reset.led1", obs_led(1), 32'd0);
        clr = 1'b1;
        line_idle(0, 4);

        // 8N1 0x0F, then acknowledge
        send(0, 9'h0F, 0, 0, 0);
        line_idle(0, 4);
        do_ack(0);

        // 7E2 0x55 with correct, then wrong, parity bit
        send(1, 9'h55, 0, 0, 0);
        line_idle(1, 4);
        do_ack(1);
        send(1, 9'h55, 1, 0, 0);
        line_idle(1, 4);
        check("parity_err.u1", 32'(if1.parity_err), 32'd1);
        do_ack(1);

        // framing error followed by a held-low break
        send(0, 9'hA5, 0, 1, 0);
        repeat (40) @(posedge clk);
        #1 check("break.led0", obs_led(0), 32'd1);
        line_idle(0, 5);
        check("break_end.led0", obs_led(0), 32'd0);
        check_state("break_end", 0);
        do_ack(0);

        // overrun, then ack coinciding with the second completion
        send(0, 9'h11, 0, 0, 0);
        send(0, 9'h22, 0, 0, 0);
        line_idle(0, 4);
        check("overrun.u0", 32'(if0.overrun), 32'd1);
        do_ack(0);
        send(0, 9'h11, 0, 0, 0);
        send(0, 9'h22, 0, 0, 1);
        line_idle(0, 4);
        check("ack_at_done.data", obs_data(0), 32'h22);
        do_ack(0);

        // start glitch shorter than half a bit
        @(posedge clk); #1 rx0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch.led0", obs_led(0), 32'd0);
        check_state("glitch", 0);

        // reset in the middle of the data bits, then a clean frame
        @(posedge clk); #1 rx0 = 1'b0;
        repeat (3 + C / 2 + 3 * C) @(posedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1; rx0 = 1'b1;
        model_reset();
        check_state("mid_reset", 0);
        check_state("mid_reset", 1);
        check("mid_reset.led0", obs_led(0), 32'd0);
        line_idle(0, 4);
        send(0, 9'h3C, 0, 0, 0);
        line_idle(0, 4);
        do_ack(0);

        // randomized traffic on both instances
        for (int n = 0; n < 24; n++) begin
            int d;
            logic [8:0] val;
            bit pflip, stop0, ackd;
            d     = int'($urandom_range(0, 1));
            val   = 9'($urandom);
            pflip = (d == 1) && ($urandom_range(0, 3) == 0);
            stop0 = ($urandom_range(0, 7) == 0);
            ackd  = !e_ov[d] && ($urandom_range(0, 3) == 0);
            send(d, val, pflip, stop0, ackd);
            line_idle(d, 4);
            if ($urandom_range(0, 1) == 1) do_ack(d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
